// File: rtl/decoder_frame_packer_pkg.sv
// Shared constants and types for the decoder frame packer.
// Symbols are packed 3 bits per field regardless of the active code rate.
package decoder_frame_packer_pkg;

   localparam int unsigned MAX_CODE_RATE  = 3;
   localparam int unsigned DFP_SYM_W      = MAX_CODE_RATE;
   localparam int unsigned DFP_FRAME_SYMS = 128;
   localparam int unsigned DFP_FRAME_W    = DFP_SYM_W * DFP_FRAME_SYMS;
   localparam int unsigned DFP_CNT_W      = 8;

   typedef enum logic [1:0] {
      BUF_EMPTY,
      BUF_FILLING,
      BUF_FULL
   } buf_state_t;

endpackage

// File: rtl/decoder_frame_packer_frame_buf.sv
// One ping-pong frame buffer: field storage, latched rate, symbol count
// and its EMPTY/FILLING/FULL state machine.
module frame_buf
   import decoder_frame_packer_pkg::*;
#(
   parameter int unsigned SYM_W      = DFP_SYM_W,
   parameter int unsigned FRAME_SYMS = DFP_FRAME_SYMS,
   parameter int unsigned FRAME_W    = DFP_FRAME_W,
   parameter int unsigned CNT_W      = DFP_CNT_W,
   parameter int unsigned IDX_W      = $clog2(FRAME_SYMS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_idx,
   input  logic [SYM_W-1:0]   wr_data,
   input  logic               rate_in,
   input  logic               close,
   input  logic [CNT_W-1:0]   count_in,
   input  logic               rel,
   output logic [FRAME_W-1:0] data,
   output logic               rate,
   output logic [CNT_W-1:0]   count,
   output logic               full
);

   buf_state_t state, state_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= BUF_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // A flush arriving with the very first symbol closes straight to FULL.
   always_comb begin
      state_nxt = state;
      case (state)
         BUF_EMPTY:   if (wr_en) state_nxt = close ? BUF_FULL : BUF_FILLING;
         BUF_FILLING: if (close) state_nxt = BUF_FULL;
         BUF_FULL:    if (rel)   state_nxt = BUF_EMPTY;
         default:     state_nxt = BUF_EMPTY;
      endcase
   end

   always_comb begin
      full = (state == BUF_FULL);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data  <= '0;
         rate  <= 1'b0;
         count <= '0;
      end else if (rel && full) begin
         data  <= '0;
         rate  <= 1'b0;
         count <= '0;
      end else begin
         if (wr_en && !full) begin
            data[wr_idx*SYM_W +: SYM_W] <= wr_data;
            if (state == BUF_EMPTY) rate <= rate_in;
         end
         if (close && !full) count <= count_in;
      end
   end

endmodule

// File: rtl/decoder_frame_packer.sv
// Packs a serial stream of 2/3-bit code symbols into 384-bit decoder frames
// using two ping-pong buffers with valid/ready handshakes on both sides.
module decoder_frame_packer
   import decoder_frame_packer_pkg::*;
#(
   parameter int unsigned SYM_W      = DFP_SYM_W,
   parameter int unsigned FRAME_SYMS = DFP_FRAME_SYMS,
   parameter int unsigned FRAME_W    = DFP_FRAME_W,
   parameter int unsigned CNT_W      = DFP_CNT_W
) (
   input  logic               sys_clk,
   input  logic               rst,
   input  logic               en,
   input  logic               i_code_rate,
   input  logic [SYM_W-1:0]   i_sym,
   input  logic               i_sym_valid,
   output logic               o_sym_ready,
   input  logic               i_flush,
   output logic [FRAME_W-1:0] o_frame,
   output logic               o_frame_valid,
   input  logic               i_frame_ready,
   output logic               o_frame_rate,
   output logic [CNT_W-1:0]   o_sym_count
);

   localparam int unsigned    IDX_W    = $clog2(FRAME_SYMS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_SYMS - 1);

   logic               wptr, rptr;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               wfull, accept, close, eff_rate, release_frame;
   logic [SYM_W-1:0]   wr_data;
   logic [CNT_W-1:0]   close_count;

   logic [1:0]         buf_wr, buf_close, buf_rel, buf_full, buf_rate;
   logic [FRAME_W-1:0] buf_data  [2];
   logic [CNT_W-1:0]   buf_count [2];

   always_comb begin
      wfull       = buf_full[wptr];
      o_sym_ready = en & ~wfull;
      accept      = i_sym_valid & o_sym_ready;

      // The first symbol takes the live rate; later ones follow the latched rate.
      eff_rate    = (cnt == '0) ? i_code_rate : buf_rate[wptr];
      wr_data     = eff_rate ? i_sym : {{(SYM_W-2){1'b0}}, i_sym[1:0]};

      close_count = accept ? cnt + 1'b1 : cnt;
      close       = (accept && (cnt == LAST_IDX)) ||
                    (en && i_flush && !wfull && ((cnt != '0) || accept));

      if (close)       cnt_nxt = '0;
      else if (accept) cnt_nxt = cnt + 1'b1;
      else             cnt_nxt = cnt;

      o_frame_valid = buf_full[rptr];
      release_frame = o_frame_valid & i_frame_ready & en;

      buf_wr          = '0;
      buf_close       = '0;
      buf_rel         = '0;
      buf_wr[wptr]    = accept;
      buf_close[wptr] = close;
      buf_rel[rptr]   = release_frame;

      o_frame      = buf_data[rptr];
      o_frame_rate = buf_rate[rptr];
      o_sym_count  = buf_count[rptr];
   end

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         wptr <= 1'b0;
         rptr <= 1'b0;
         cnt  <= '0;
      end else begin
         cnt <= cnt_nxt;
         if (close)         wptr <= ~wptr;
         if (release_frame) rptr <= ~rptr;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_buf
      frame_buf #(
         .SYM_W      (SYM_W),
         .FRAME_SYMS (FRAME_SYMS),
         .FRAME_W    (FRAME_W),
         .CNT_W      (CNT_W),
         .IDX_W      (IDX_W)
      ) u_buf (
         .clk      (sys_clk),
         .rst      (rst),
         .wr_en    (buf_wr[g]),
         .wr_idx   (cnt[IDX_W-1:0]),
         .wr_data  (wr_data),
         .rate_in  (i_code_rate),
         .close    (buf_close[g]),
         .count_in (close_count),
         .rel      (buf_rel[g]),
         .data     (buf_data[g]),
         .rate     (buf_rate[g]),
         .count    (buf_count[g]),
         .full     (buf_full[g])
      );
   end

endmodule

// File: tb/tb_decoder_frame_packer.sv
// Randomized checks of the frame packer against a queue-based model of
// completed frames plus one partial frame.
module tb_decoder_frame_packer;

   localparam int FRAME_W = 384;

   logic               sys_clk = 1'b0;
   logic               rst = 1'b0;
   logic               en = 1'b0;
   logic               i_code_rate = 1'b0;
   logic [2:0]         i_sym = '0;
   logic               i_sym_valid = 1'b0;
   logic               i_flush = 1'b0;
   logic               i_frame_ready = 1'b0;
   logic               o_sym_ready;
   logic [FRAME_W-1:0] o_frame;
   logic               o_frame_valid;
   logic               o_frame_rate;
   logic [7:0]         o_sym_count;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [FRAME_W-1:0] data;
      int                 count;
      bit                 rate;
   } frame_t;

   frame_t     done_q[$];
   logic [2:0] part[$];
   bit         part_rate;

   decoder_frame_packer dut (
      .sys_clk       (sys_clk),
      .rst           (rst),
      .en            (en),
      .i_code_rate   (i_code_rate),
      .i_sym         (i_sym),
      .i_sym_valid   (i_sym_valid),
      .o_sym_ready   (o_sym_ready),
      .i_flush       (i_flush),
      .o_frame       (o_frame),
      .o_frame_valid (o_frame_valid),
      .i_frame_ready (i_frame_ready),
      .o_frame_rate  (o_frame_rate),
      .o_sym_count   (o_sym_count)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic model_reset();
      done_q.delete();
      part.delete();
      part_rate = 1'b0;
   endtask

   task automatic idle_inputs();
      i_sym_valid   = 1'b0;
      i_flush       = 1'b0;
      i_frame_ready = 1'b0;
   endtask

   // One clock edge; the model advances from the inputs held across it.
   task automatic cycle();
      bit acc, rel, fl;
      int sz;
      frame_t f;
      sz  = done_q.size();
      acc = en && i_sym_valid && (sz < 2);
      rel = en && i_frame_ready && (sz > 0);
      fl  = en && i_flush && (sz < 2);
      @(posedge sys_clk);
      if (rel) void'(done_q.pop_front());
      if (acc) begin
         if (part.size() == 0) part_rate = i_code_rate;
         part.push_back(part_rate ? i_sym : {1'b0, i_sym[1:0]});
      end
      if (part.size() == 128 || (fl && part.size() > 0)) begin
         f.data  = '0;
         for (int k = 0; k < part.size(); k++) f.data[3*k +: 3] = part[k];
         f.count = part.size();
         f.rate  = part_rate;
         done_q.push_back(f);
         part.delete();
      end
      #1;
   endtask

   task automatic send_syms(input int n, input int start, input bit rate, input bit all_ones);
      for (int k = 0; k < n; k++) begin
         i_sym_valid = 1'b1;
         i_sym       = all_ones ? 3'b111 : 3'((start + k) % 8);
         i_code_rate = rate;
         cycle();
      end
      i_sym_valid = 1'b0;
   endtask

   task automatic check_head(input string tag);
      frame_t h;
      n_vec++;
      if (done_q.size() == 0 || o_frame_valid !== 1'b1) begin
         n_err++;
         $display("FAIL %s valid: got %b want 1 (model frames %0d)", tag, o_frame_valid, done_q.size());
         return;
      end
      h = done_q[0];
      n_vec++;
      if (o_frame !== h.data) begin
         n_err++;
         $display("FAIL %s frame: got %h want %h", tag, o_frame, h.data);
      end
      n_vec++;
      if (o_sym_count !== 8'(h.count)) begin
         n_err++;
         $display("FAIL %s count: got %0d want %0d", tag, o_sym_count, h.count);
      end
      n_vec++;
      if (o_frame_rate !== h.rate) begin
         n_err++;
         $display("FAIL %s rate: got %b want %b", tag, o_frame_rate, h.rate);
      end
   endtask

   task automatic drain(input string tag);
      i_sym_valid   = 1'b0;
      i_flush       = 1'b0;
      i_frame_ready = 1'b1;
      for (int k = 0; k < 8 && done_q.size() > 0; k++) cycle();
      i_frame_ready = 1'b0;
      n_vec++;
      if (o_frame_valid !== 1'b0 || done_q.size() != 0) begin
         n_err++;
         $display("FAIL %s drain: valid got %b want 0 (model frames %0d)", tag, o_frame_valid, done_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      en  = 1'b0;
      idle_inputs();
      model_reset();
      #12;
      n_vec++;
      if (o_frame_valid !== 1'b0 || o_frame !== '0 || o_sym_ready !== 1'b0 ||
          o_sym_count !== 8'd0 || o_frame_rate !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got v=%b rdy=%b cnt=%0d rate=%b frame_nz=%b want 0 0 0 0 0",
                  o_frame_valid, o_sym_ready, o_sym_count, o_frame_rate, |o_frame);
      end
      @(negedge sys_clk);
      rst = 1'b1;
      @(posedge sys_clk);
      #1;
      en = 1'b1;
      #1;
      n_vec++;
      if (o_sym_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready_en: got %b want 1", o_sym_ready);
      end
      n_vec++;
      if (o_frame_valid !== 1'b0 || o_frame !== '0 || o_sym_count !== 8'd0) begin
         n_err++;
         $display("FAIL reset_en_outputs: got v=%b cnt=%0d frame_nz=%b want 0 0 0",
                  o_frame_valid, o_sym_count, |o_frame);
      end
   endtask

   task automatic test_rate13_full();
      logic [FRAME_W-1:0] f;
      send_syms(127, 0, 1'b1, 1'b0);
      n_vec++;
      if (o_frame_valid !== 1'b0) begin
         n_err++;
         $display("FAIL r13_early_valid: got %b want 0", o_frame_valid);
      end
      send_syms(1, 127, 1'b1, 1'b0);
      check_head("r13");
      f = o_frame;
      n_vec++;
      if (f[2:0] !== 3'd0 || f[5:3] !== 3'd1 || f[383:381] !== 3'd7) begin
         n_err++;
         $display("FAIL r13_fields: got %0d %0d %0d want 0 1 7", f[2:0], f[5:3], f[383:381]);
      end
      drain("r13");
   endtask

   task automatic test_back_to_back();
      logic [FRAME_W-1:0] first;
      i_sym_valid = 1'b1;
      i_code_rate = 1'b1;
      for (int k = 0; k < 256; k++) begin
         i_sym = 3'($urandom_range(0, 7));
         cycle();
      end
      n_vec++;
      if (o_sym_ready !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_ready_drop: got %b want 0", o_sym_ready);
      end
      check_head("b2b_first");
      first = o_frame;
      for (int k = 0; k < 3; k++) begin
         i_sym = 3'($urandom_range(0, 7));
         cycle();
         n_vec++;
         if (o_sym_ready !== 1'b0 || o_frame !== first) begin
            n_err++;
            $display("FAIL b2b_hold: ready got %b want 0, frame_changed=%b", o_sym_ready, o_frame !== first);
         end
      end
      i_sym_valid   = 1'b0;
      i_frame_ready = 1'b1;
      cycle();
      i_frame_ready = 1'b0;
      check_head("b2b_second");
      n_vec++;
      if (o_sym_ready !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_ready_rise: got %b want 1", o_sym_ready);
      end
      drain("b2b");
   endtask

   task automatic test_rate12();
      logic [FRAME_W-1:0] exp;
      exp = '0;
      for (int k = 0; k < 128; k++) exp[3*k +: 3] = 3'b011;
      for (int k = 0; k < 128; k++) begin
         i_sym_valid = 1'b1;
         i_sym       = 3'b111;
         i_code_rate = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         cycle();
      end
      i_sym_valid = 1'b0;
      check_head("r12");
      n_vec++;
      if (o_frame !== exp || o_frame_rate !== 1'b0) begin
         n_err++;
         $display("FAIL r12_fields: got %h rate %b want %h rate 0", o_frame, o_frame_rate, exp);
      end
      drain("r12");
   endtask

   task automatic test_flush();
      logic [FRAME_W-1:0] f;
      i_flush = 1'b1;
      cycle();
      i_flush = 1'b0;
      n_vec++;
      if (o_frame_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush_empty_ignored: got %b want 0", o_frame_valid);
      end
      send_syms(5, $urandom_range(0, 7), 1'b1, 1'b0);
      i_flush = 1'b1;
      cycle();
      i_flush = 1'b0;
      check_head("flush5");
      f = o_frame;
      n_vec++;
      if (o_sym_count !== 8'd5 || f[383:15] !== '0) begin
         n_err++;
         $display("FAIL flush5_shape: count got %0d want 5, upper_nz got %b want 0", o_sym_count, |f[383:15]);
      end
      drain("flush5");
      send_syms(5, 3, 1'b0, 1'b0);
      i_sym_valid = 1'b1;
      i_sym       = 3'b110;
      i_flush     = 1'b1;
      cycle();
      i_sym_valid = 1'b0;
      i_flush     = 1'b0;
      check_head("flush6");
      n_vec++;
      if (o_sym_count !== 8'd6) begin
         n_err++;
         $display("FAIL flush6_count: got %0d want 6", o_sym_count);
      end
      drain("flush6");
   endtask

   task automatic test_en_freeze();
      logic [FRAME_W-1:0] held;
      send_syms(128, 5, 1'b1, 1'b0);
      send_syms(10, 0, 1'b1, 1'b0);
      held = o_frame;
      en            = 1'b0;
      i_sym_valid   = 1'b1;
      i_flush       = 1'b1;
      i_frame_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle();
         n_vec++;
         if (o_sym_ready !== 1'b0 || o_frame_valid !== 1'b1 || o_frame !== held) begin
            n_err++;
            $display("FAIL en_freeze: ready got %b want 0, valid got %b want 1, frame_changed=%b",
                     o_sym_ready, o_frame_valid, o_frame !== held);
         end
      end
      en = 1'b1;
      idle_inputs();
      drain("en_first");
      send_syms(118, 2, 1'b0, 1'b0);
      check_head("en_resume");
      drain("en_resume");
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         en            = ($urandom_range(0, 9) != 0);
         i_sym_valid   = ($urandom_range(0, 9) < 7);
         i_sym         = 3'($urandom_range(0, 7));
         i_code_rate   = 1'($urandom_range(0, 1));
         i_flush       = ($urandom_range(0, 39) == 0);
         i_frame_ready = ($urandom_range(0, 9) < 3);
         cycle();
         n_vec++;
         if (o_frame_valid !== (done_q.size() > 0) || o_sym_ready !== (en && done_q.size() < 2)) begin
            n_err++;
            $display("FAIL rand_hs c=%0d: valid %b ready %b want %b %b", c, o_frame_valid, o_sym_ready,
                     done_q.size() > 0, en && done_q.size() < 2);
         end else if (o_frame_valid) begin
            check_head("rand");
         end
      end
      en = 1'b1;
      idle_inputs();
      drain("rand");
      if (part.size() > 0) begin
         i_flush = 1'b1;
         cycle();
         i_flush = 1'b0;
         check_head("rand_tail");
         drain("rand_tail");
      end
   endtask

   task automatic test_reset_mid();
      send_syms(128, 1, 1'b1, 1'b0);
      send_syms(60, 4, 1'b0, 1'b0);
      check_head("rst_pre");
      @(posedge sys_clk);
      #2;
      rst = 1'b0;
      #1;
      n_vec++;
      if (o_frame_valid !== 1'b0 || o_frame !== '0 || o_sym_count !== 8'd0) begin
         n_err++;
         $display("FAIL rst_mid_outputs: valid %b count %0d frame_nz %b want 0 0 0",
                  o_frame_valid, o_sym_count, |o_frame);
      end
      model_reset();
      #3;
      rst = 1'b1;
      send_syms(128, 6, 1'b1, 1'b0);
      check_head("rst_post");
      drain("rst_post");
   endtask

   initial begin
      test_reset();
      test_rate13_full();
      test_back_to_back();
      test_rate12();
      test_flush();
      test_en_freeze();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
